// File: rtl/dvp_line_arbiter_pkg.sv
// Shared types and widths for the two-channel DVP line arbiter.
// No logic here, so there is no latency and no backpressure.
package dvp_line_arbiter_pkg;

    localparam int NUM_CH = 2;
    localparam int PIX_W  = 8;
    localparam int RD_W   = 10;
    localparam int CNT_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_GAP
    } state_t;

    // Pick a channel from the ready mask. Used only when at least one bit is set.
    function automatic logic pick_ch(input logic [NUM_CH-1:0] rdy, input logic rr_ptr);
        if (&rdy) begin
            return rr_ptr;
        end
        return rdy[1];
    endfunction

endpackage

// File: rtl/dvp_line_arbiter_if.sv
// Channel FIFO read side, merged pixel stream and frame status of the line arbiter.
// Wires only: no latency and no backpressure.
interface dvp_line_arbiter_if;
    import dvp_line_arbiter_pkg::*;

    logic                enable;
    logic [NUM_CH-1:0]   line_ready;
    logic [NUM_CH-1:0]   frame_start;
    logic [RD_W-1:0]     rd_data0;
    logic [RD_W-1:0]     rd_data1;
    logic [NUM_CH-1:0]   rd_en;
    logic [PIX_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ch;
    logic                out_sol;
    logic                out_eol;
    logic [CNT_W-1:0]    line_cnt0;
    logic [CNT_W-1:0]    line_cnt1;
    logic                pair_done;
    logic [NUM_CH-1:0]   err_short;

    modport master (
        input  enable, line_ready, frame_start, rd_data0, rd_data1,
        output rd_en, out_data, out_valid, out_ch, out_sol, out_eol,
               line_cnt0, line_cnt1, pair_done, err_short
    );

    modport slave (
        output enable, line_ready, frame_start, rd_data0, rd_data1,
        input  rd_en, out_data, out_valid, out_ch, out_sol, out_eol,
               line_cnt0, line_cnt1, pair_done, err_short
    );

endinterface

// File: rtl/dvp_frame_tracker.sv
// Per-channel line counter (saturating) with sticky short-frame flag.
// Count updates one cycle after the end-of-line pulse; never stalls.
module dvp_frame_tracker
    import dvp_line_arbiter_pkg::*;
#(
    parameter int LINES_PER_FRAME = 720
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             eol,
    input  logic             frame_start,
    output logic [CNT_W-1:0] line_cnt,
    output logic             err_short,
    output logic             full
);

    localparam logic [CNT_W-1:0] LPF = CNT_W'(LINES_PER_FRAME);

    logic [CNT_W-1:0] line_cnt_q, line_cnt_d, cnt_with_eol;
    logic             err_short_q, err_short_d;

    always_comb begin
        cnt_with_eol = line_cnt_q;
        if (eol && (line_cnt_q != LPF)) begin
            cnt_with_eol = line_cnt_q + 1'b1;
        end
        // A line ending in the frame_start cycle still belongs to the old frame.
        line_cnt_d  = frame_start ? '0 : cnt_with_eol;
        err_short_d = err_short_q |
                      (frame_start && (cnt_with_eol != '0) && (cnt_with_eol != LPF));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            line_cnt_q  <= '0;
            err_short_q <= 1'b0;
        end else begin
            line_cnt_q  <= line_cnt_d;
            err_short_q <= err_short_d;
        end
    end

    assign line_cnt  = line_cnt_q;
    assign err_short = err_short_q;
    assign full      = (line_cnt_q == LPF);

endmodule

// File: rtl/dvp_line_arbiter.sv
// Round-robin line arbiter merging two DVP channel FIFOs into one pixel stream.
// rd_en -> out_valid is one cycle; grants wait for line_ready and enable, a granted line never stalls.
module dvp_line_arbiter
    import dvp_line_arbiter_pkg::*;
#(
    parameter int LINE_LEN        = 1280,
    parameter int LINES_PER_FRAME = 720,
    parameter int GAP_CYC         = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    dvp_line_arbiter_if.master bus
);

    localparam int PCNT_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int GCNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(LINE_LEN - 1);
    localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t              state_q, state_d;
    logic                cur_ch_q, cur_ch_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]   rd_en_q, rd_en_d;
    logic [PCNT_W-1:0]   pix_q, pix_d;
    logic [GCNT_W-1:0]   gap_q, gap_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sol_q, out_sol_d;
    logic                out_eol_q, out_eol_d;
    logic                pair_done_q, pair_done_d;
    logic                pair_armed_q, pair_armed_d;
    logic [NUM_CH-1:0]   pair_clr_q, pair_clr_d;
    logic                arb_slot, grant_ch;
    logic [NUM_CH-1:0]   eol_ch, full, err_short;
    logic [CNT_W-1:0]    line_cnt0, line_cnt1;
    logic [3:0]          flags_unused;

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        rr_ptr_d    = rr_ptr_q;
        rd_en_d     = rd_en_q;
        pix_d       = pix_q;
        gap_d       = gap_q;
        arb_slot    = 1'b0;
        grant_ch    = pick_ch(bus.line_ready, rr_ptr_q);
        out_valid_d = |rd_en_q;
        out_sol_d   = (|rd_en_q) && (pix_q == '0);
        out_eol_d   = (|rd_en_q) && (pix_q == LAST_PIX);

        case (state_q)
            ST_IDLE:  arb_slot = 1'b1;
            ST_READ: begin
                if (pix_q == LAST_PIX) begin
                    state_d = ST_DRAIN;
                    rd_en_d = '0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (GAP_CYC == 0) begin
                    state_d  = ST_IDLE;
                    arb_slot = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                // The final gap cycle doubles as the arbitration cycle.
                if (gap_q == LAST_GAP) begin
                    state_d  = ST_IDLE;
                    arb_slot = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (arb_slot && bus.enable && (|bus.line_ready)) begin
            state_d  = ST_READ;
            cur_ch_d = grant_ch;
            rr_ptr_d = ~grant_ch;
            rd_en_d  = grant_ch ? 2'b10 : 2'b01;
            pix_d    = '0;
        end
    end

    // Pair completion fires once, then waits until both counters have been seen at zero.
    always_comb begin
        pair_done_d  = pair_armed_q && (&full);
        pair_armed_d = pair_armed_q;
        pair_clr_d   = pair_clr_q;
        if (pair_done_d) begin
            pair_armed_d = 1'b0;
            pair_clr_d   = '0;
        end else if (!pair_armed_q) begin
            pair_clr_d = pair_clr_q | {line_cnt1 == '0, line_cnt0 == '0};
            if (&pair_clr_d) begin
                pair_armed_d = 1'b1;
                pair_clr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_ch_q     <= 1'b0;
            rr_ptr_q     <= 1'b0;
            rd_en_q      <= '0;
            pix_q        <= '0;
            gap_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            pair_done_q  <= 1'b0;
            pair_armed_q <= 1'b1;
            pair_clr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            rr_ptr_q     <= rr_ptr_d;
            rd_en_q      <= rd_en_d;
            pix_q        <= pix_d;
            gap_q        <= gap_d;
            out_valid_q  <= out_valid_d;
            out_sol_q    <= out_sol_d;
            out_eol_q    <= out_eol_d;
            pair_done_q  <= pair_done_d;
            pair_armed_q <= pair_armed_d;
            pair_clr_q   <= pair_clr_d;
        end
    end

    assign eol_ch = {out_eol_q & cur_ch_q, out_eol_q & ~cur_ch_q};

    dvp_frame_tracker #(.LINES_PER_FRAME(LINES_PER_FRAME)) u_trk0 (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .eol        (eol_ch[0]),
        .frame_start(bus.frame_start[0]),
        .line_cnt   (line_cnt0),
        .err_short  (err_short[0]),
        .full       (full[0])
    );

    dvp_frame_tracker #(.LINES_PER_FRAME(LINES_PER_FRAME)) u_trk1 (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .eol        (eol_ch[1]),
        .frame_start(bus.frame_start[1]),
        .line_cnt   (line_cnt1),
        .err_short  (err_short[1]),
        .full       (full[1])
    );

    assign flags_unused  = {bus.rd_data1[9:8], bus.rd_data0[9:8]};
    assign bus.rd_en     = rd_en_q;
    assign bus.out_data  = out_valid_q ? (cur_ch_q ? bus.rd_data1[PIX_W-1:0]
                                                   : bus.rd_data0[PIX_W-1:0]) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = cur_ch_q;
    assign bus.out_sol   = out_sol_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.line_cnt0 = line_cnt0;
    assign bus.line_cnt1 = line_cnt1;
    assign bus.pair_done = pair_done_q;
    assign bus.err_short = err_short;

endmodule

// File: doc/dvp_line_arbiter.md
DVP_LINE_ARBITER -- requirements
Module: dvp_line_arbiter

Interface
REQ-001 Parameter LINE_LEN, default 1280: pixels per line read from a channel FIFO per grant.
REQ-002 Parameter LINES_PER_FRAME, default 720: expected lines per frame per channel.
REQ-003 Parameter GAP_CYC, default 2: idle cycles inserted after each line before the next grant.
REQ-004 clk_sys  input  1  system clock; all logic is single-clock on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  level; when low, no new grant is issued.
REQ-007 line_ready  input  2  per channel; level, high while that channel FIFO holds at least LINE_LEN words.
REQ-008 frame_start  input  2  per channel; 1-cycle pulse, clk_sys domain, marks a new frame.
REQ-009 rd_data0 / rd_data1  input  10 each  FIFO read data; [7:0] pixel, [9:8] line flags (ignored), 1-cycle read latency.
REQ-010 rd_en  output  2  one-hot FIFO read strobe to the granted channel.
REQ-011 out_data  output  8  muxed pixel.
REQ-012 out_valid, out_ch, out_sol, out_eol  output  1 each  pixel valid, source channel, first pixel of line, last pixel of line.
REQ-013 line_cnt0 / line_cnt1  output  10 each  lines completed in the current frame per channel.
REQ-014 pair_done  output  1  1-cycle pulse when both channels have completed LINES_PER_FRAME lines.
REQ-015 err_short  output  2  sticky per channel: frame_start seen with line count != LINES_PER_FRAME (count nonzero).

Function
REQ-016 FSM states: IDLE, READ, DRAIN, GAP.
REQ-017 IDLE -> READ when enable=1 and any line_ready bit=1; grant is latched into cur_ch for the whole line.
REQ-018 Grant rule: if both ready, grant channel selected by rr_ptr; if one ready, grant it; rr_ptr becomes the non-granted channel after every grant.
REQ-019 READ: rd_en[cur_ch]=1 for exactly LINE_LEN consecutive cycles (pix counter 0..LINE_LEN-1), then DRAIN.
REQ-020 DRAIN: one cycle, no rd_en, captures last FIFO word; then GAP.
REQ-021 GAP: GAP_CYC cycles (GAP_CYC=0 means direct DRAIN -> IDLE), then IDLE.
REQ-022 out_valid = rd_en of previous cycle; out_data = rd_data of cur_ch; out_ch = cur_ch; latency rd_en -> out_valid is exactly 1 cycle.
REQ-023 out_sol high with the first out_valid of a line; out_eol high with the LINE_LEN-th; LINE_LEN=1 asserts both together.
REQ-024 enable falling mid-line: current line completes unchanged; no further grant.
REQ-025 line_ready dropping mid-line is ignored (contract: FIFO already holds a full line).
REQ-026 line_cnt[ch] increments on out_eol of that channel and saturates at LINES_PER_FRAME.
REQ-027 frame_start[ch]: line_cnt[ch] cleared to 0; if previous count was nonzero and != LINES_PER_FRAME, err_short[ch] set.
REQ-028 frame_start and out_eol on same channel in same cycle: the line counts toward the old frame (checked as count+1), then counter clears to 0.
REQ-029 pair_done pulses in the cycle after the second channel reaches LINES_PER_FRAME; at most once per frame pair, re-armed when both counters have been cleared.
REQ-030 err_short cleared only by reset.

Reset
REQ-031 On reset: state=IDLE, rr_ptr=0, rd_en=0, out_valid/out_sol/out_eol/out_ch=0, out_data=0, line_cnt0/1=0, pair_done=0, err_short=0; effective immediately, including mid-line (partial line discarded, no out_eol).

Structure
REQ-032 Shared package holds FSM state enum, pixel/flag widths (8, 10) and channel count (2).
REQ-033 One sub-module natural: dvp_frame_tracker, instantiated per channel (line_cnt, err_short, saturation).

Verification (LINE_LEN=8, LINES_PER_FRAME=4, GAP_CYC=2)
REQ-034 line_ready=2'b01 held -> rd_en=01 for 8 cycles, out_valid 8 cycles starting 1 later, out_sol on pixel 0, out_eol on pixel 7, next rd_en 4 cycles after last.
REQ-035 line_ready=2'b11 held -> grants alternate 0,1,0,1; out_ch toggles per line.
REQ-036 4 lines per channel -> line_cnt0=line_cnt1=4, single pair_done pulse; a 5th line leaves count 4.
REQ-037 3 lines on ch1 then frame_start[1] -> err_short=2'b10, line_cnt1=0.
REQ-038 reset asserted at pixel 3 of a line -> all outputs 0 next edge, no out_eol; after release grant resumes from channel 0.
REQ-039 frame_start[0] coincident with 4th out_eol on ch0 -> err_short[0] stays 0, line_cnt0=0.
